// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program sequencer: state encoding, default
// parameter values and a select-width helper.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int DEF_PC_W      = 11;
  localparam int DEF_OFF_W     = 8;
  localparam int DEF_NUM_PROG  = 3;
  localparam int DEF_RAS_DEPTH = 4;

  // A one-program build still gets a 1-bit select so the port never vanishes.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack, DEPTH x W. Push on full and pop on empty are ignored;
// the caller is responsible for flagging those cases.
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;

  assign full  = (32'(cnt) == DEPTH);
  assign empty = (cnt == '0);
  // Only meaningful while non-empty.
  assign top   = mem[IDX_W'(cnt - 1'b1)];

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[IDX_W'(cnt)] <= push_data;
      cnt              <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program counter sequencer with selectable start addresses, relative branch,
// absolute jump and call/return through a small return-address stack.
//
// state   | meaning
// IDLE    | program loaded (or Start held); PC parked at base address
// RUN     | fetching; PC advances per control inputs
// DONE    | Halt seen; PC frozen until Start or Reset
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int NUM_PROG  = DEF_NUM_PROG,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  parameter logic [NUM_PROG-1:0][PC_W-1:0] PROG_BASE = '0
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            Start,
  input  logic [sel_width(NUM_PROG)-1:0]  ProgSel,
  input  logic                            Stall,
  input  logic                            Halt,
  input  logic                            BranchRelEn,
  input  logic                            ALU_flag,
  input  logic [OFF_W-1:0]                Offset,
  input  logic                            JumpAbsEn,
  input  logic [PC_W-1:0]                 JumpTarget,
  input  logic                            CallEn,
  input  logic                            RetEn,
  output logic [PC_W-1:0]                 ProgCtr,
  output logic                            Running,
  output logic                            Done,
  output logic                            RasOverflow,
  output logic                            RasUnderflow
);

  seq_state_t      state, state_n;
  logic [PC_W-1:0] pc_n, pc_inc, off_ext, base_sel;
  logic            ovf_n, unf_n;
  logic            ras_push, ras_pop, ras_clr;
  logic            ras_full, ras_empty;
  logic [PC_W-1:0] ras_top;

  assign pc_inc  = ProgCtr + PC_W'(1);
  assign off_ext = PC_W'($signed(Offset));
  assign base_sel = (32'(ProgSel) < NUM_PROG) ? PROG_BASE[ProgSel] : PROG_BASE[0];

  assign Running = (state == ST_RUN);
  assign Done    = (state == ST_DONE);

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (ras_clr),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .full      (ras_full),
    .empty     (ras_empty),
    .top       (ras_top)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      ProgCtr      <= PROG_BASE[0];
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
    end else begin
      state        <= state_n;
      ProgCtr      <= pc_n;
      RasOverflow  <= ovf_n;
      RasUnderflow <= unf_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = ProgCtr;
    ovf_n    = RasOverflow;
    unf_n    = RasUnderflow;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ras_clr  = 1'b0;

    if (Start) begin
      state_n = ST_IDLE;
      pc_n    = base_sel;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
      ras_clr = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: state_n = ST_RUN;
        ST_RUN: begin
          if (Stall) begin
            pc_n = ProgCtr;
          end else if (Halt) begin
            state_n = ST_DONE;
          end else if (RetEn) begin
            // Underflowing return falls through to the next instruction.
            if (!ras_empty) begin
              ras_pop = 1'b1;
              pc_n    = ras_top;
            end else begin
              unf_n = 1'b1;
              pc_n  = pc_inc;
            end
          end else if (CallEn) begin
            if (!ras_full) ras_push = 1'b1;
            else           ovf_n    = 1'b1;
            pc_n = JumpTarget;
          end else if (JumpAbsEn) begin
            pc_n = JumpTarget;
          end else if (BranchRelEn && ALU_flag) begin
            pc_n = ProgCtr + off_ext;
          end else begin
            pc_n = pc_inc;
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench: each stimulus cycle pushes its expected post-edge outputs
// into a queue; an independent monitor pops and compares after every edge.
module tb_prog_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, Halt, BranchRelEn, ALU_flag;
  logic        JumpAbsEn, CallEn, RetEn;
  logic [1:0]  ProgSel;
  logic [7:0]  Offset;
  logic [10:0] JumpTarget;
  logic [10:0] ProgCtr;
  logic        Running, Done, RasOverflow, RasUnderflow;

  typedef struct {
    string       nm;
    logic [10:0] pc;
    logic        r, d, o, u;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  prog_sequencer #(
    .PC_W      (11),
    .OFF_W     (8),
    .NUM_PROG  (3),
    .RAS_DEPTH (4),
    .PROG_BASE ({11'h7FE, 11'h100, 11'h000})
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .ProgSel      (ProgSel),
    .Stall        (Stall),
    .Halt         (Halt),
    .BranchRelEn  (BranchRelEn),
    .ALU_flag     (ALU_flag),
    .Offset       (Offset),
    .JumpAbsEn    (JumpAbsEn),
    .JumpTarget   (JumpTarget),
    .CallEn       (CallEn),
    .RetEn        (RetEn),
    .ProgCtr      (ProgCtr),
    .Running      (Running),
    .Done         (Done),
    .RasOverflow  (RasOverflow),
    .RasUnderflow (RasUnderflow)
  );

  always #5 Clk = ~Clk;

  task automatic idle_inputs();
    Reset = 0; Start = 0; ProgSel = 0; Stall = 0; Halt = 0;
    BranchRelEn = 0; ALU_flag = 0; Offset = 0; JumpAbsEn = 0;
    JumpTarget = 0; CallEn = 0; RetEn = 0;
  endtask

  // Queue the expected result of the upcoming edge, then step to the next
  // negedge and drop all controls.
  task automatic cyc(input string nm, input logic [10:0] pc,
                     input logic r, input logic d, input logic o, input logic u);
    exp_t e;
    e.nm = nm; e.pc = pc; e.r = r; e.d = d; e.o = o; e.u = u;
    sb.push_back(e);
    @(negedge Clk);
    idle_inputs();
  endtask

  task automatic jump(input logic [10:0] t);
    JumpAbsEn = 1; JumpTarget = t;
    cyc("jump", t, 1, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (ProgCtr !== e.pc) begin
          n_bad++;
          $display("FAIL %s ProgCtr got %h want %h", e.nm, ProgCtr, e.pc);
        end
        if (Running !== e.r) begin
          n_bad++;
          $display("FAIL %s Running got %b want %b", e.nm, Running, e.r);
        end
        if (Done !== e.d) begin
          n_bad++;
          $display("FAIL %s Done got %b want %b", e.nm, Done, e.d);
        end
        if (RasOverflow !== e.o) begin
          n_bad++;
          $display("FAIL %s RasOverflow got %b want %b", e.nm, RasOverflow, e.o);
        end
        if (RasUnderflow !== e.u) begin
          n_bad++;
          $display("FAIL %s RasUnderflow got %b want %b", e.nm, RasUnderflow, e.u);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    idle_inputs();
    @(negedge Clk);

    Reset = 1;                        cyc("reset",    11'h000, 0, 0, 0, 0);
    Start = 1; ProgSel = 1;           cyc("load1",    11'h100, 0, 0, 0, 0);
                                      cyc("release",  11'h100, 1, 0, 0, 0);
                                      cyc("inc1",     11'h101, 1, 0, 0, 0);
                                      cyc("inc2",     11'h102, 1, 0, 0, 0);

    jump(11'h010);
    BranchRelEn = 1; ALU_flag = 1; Offset = 8'hFC;
                                      cyc("br_taken", 11'h00C, 1, 0, 0, 0);
    jump(11'h010);
    BranchRelEn = 1; ALU_flag = 0; Offset = 8'hFC;
                                      cyc("br_not",   11'h011, 1, 0, 0, 0);

    jump(11'h7FF);
                                      cyc("inc_wrap", 11'h000, 1, 0, 0, 0);
    jump(11'h7FE);
    BranchRelEn = 1; ALU_flag = 1; Offset = 8'h03;
                                      cyc("br_wrap",  11'h001, 1, 0, 0, 0);

    Start = 1; ProgSel = 3;           cyc("sel_oor",  11'h000, 0, 0, 0, 0);
    Start = 1; ProgSel = 2;           cyc("load2",    11'h7FE, 0, 0, 0, 0);
                                      cyc("release2", 11'h7FE, 1, 0, 0, 0);
                                      cyc("inc7ff",   11'h7FF, 1, 0, 0, 0);
                                      cyc("inc000",   11'h000, 1, 0, 0, 0);

    jump(11'h020);
    CallEn = 1; JumpTarget = 11'h040; cyc("call1",    11'h040, 1, 0, 0, 0);
    CallEn = 1; JumpTarget = 11'h060; cyc("call2",    11'h060, 1, 0, 0, 0);
    CallEn = 1; JumpTarget = 11'h080; cyc("call3",    11'h080, 1, 0, 0, 0);
    Stall = 1; CallEn = 1; JumpTarget = 11'h200;
                                      cyc("stall",    11'h080, 1, 0, 0, 0);
    CallEn = 1; JumpTarget = 11'h0A0; cyc("call4",    11'h0A0, 1, 0, 0, 0);
    CallEn = 1; JumpTarget = 11'h0C0; cyc("call5_ovf",11'h0C0, 1, 0, 1, 0);
    RetEn = 1;                        cyc("ret1",     11'h081, 1, 0, 1, 0);
    RetEn = 1;                        cyc("ret2",     11'h061, 1, 0, 1, 0);
    RetEn = 1;                        cyc("ret3",     11'h041, 1, 0, 1, 0);
    RetEn = 1;                        cyc("ret4",     11'h021, 1, 0, 1, 0);
    RetEn = 1;                        cyc("ret5_unf", 11'h022, 1, 0, 1, 1);
                                      cyc("inc_post", 11'h023, 1, 0, 1, 1);

    Halt = 1; RetEn = 1;              cyc("halt",     11'h023, 0, 1, 1, 1);
    JumpAbsEn = 1; JumpTarget = 11'h300;
                                      cyc("done_hold",11'h023, 0, 1, 1, 1);

    Start = 1; ProgSel = 0;           cyc("restart",  11'h000, 0, 0, 0, 0);
                                      cyc("release3", 11'h000, 1, 0, 0, 0);
                                      cyc("inc3",     11'h001, 1, 0, 0, 0);
    RetEn = 1;                        cyc("unf_set",  11'h002, 1, 0, 0, 1);
    CallEn = 1; JumpTarget = 11'h050; cyc("call_pre", 11'h050, 1, 0, 0, 1);
    Reset = 1; Start = 1; ProgSel = 1; Stall = 1; CallEn = 1;
                                      cyc("reset_mid",11'h000, 0, 0, 0, 0);
                                      cyc("release4", 11'h000, 1, 0, 0, 0);
    RetEn = 1;                        cyc("ras_empty",11'h001, 1, 0, 0, 1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 11, program-counter width in bits.
REQ-002 SHALL have parameter OFF_W, default 8, signed relative-branch offset width.
REQ-003 SHALL have parameter NUM_PROG, default 3, number of selectable programs.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (>=1).
REQ-005 SHALL have parameter PROG_BASE, default {0,0,0} (NUM_PROG x PC_W), program start addresses.
REQ-006 SHALL have port Clk  in  1  clock; all state changes on rising edge only.
REQ-007 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port Start  in  1  hold-and-load; release begins selected program.
REQ-009 SHALL have port ProgSel  in  clog2(NUM_PROG)  program index sampled while Start high.
REQ-010 SHALL have port Stall  in  1  freeze PC and stack this cycle.
REQ-011 SHALL have port Halt  in  1  current instruction is end-of-program.
REQ-012 SHALL have port BranchRelEn  in  1  conditional relative branch.
REQ-013 SHALL have port ALU_flag  in  1  branch condition.
REQ-014 SHALL have port Offset  in  OFF_W  signed two's-complement branch offset.
REQ-015 SHALL have port JumpAbsEn  in  1  unconditional absolute jump.
REQ-016 SHALL have port JumpTarget  in  PC_W  absolute target for jump/call.
REQ-017 SHALL have port CallEn  in  1  push ProgCtr+1, jump to JumpTarget.
REQ-018 SHALL have port RetEn  in  1  pop return address into PC.
REQ-019 SHALL have ports ProgCtr  out  PC_W  PC; Running  out  1  state RUN; Done  out  1  state DONE.
REQ-020 SHALL have ports RasOverflow, RasUnderflow  out  1 each  sticky stack error flags.

Function
REQ-021 SHALL implement states IDLE, RUN, DONE; Running/Done decode state directly (registered).
REQ-022 SHALL, in any state while Start=1, load ProgCtr <= PROG_BASE[ProgSel], clear stack and both error flags, enter IDLE.
REQ-023 SHALL, in IDLE with Start=0, enter RUN next cycle with ProgCtr unchanged (first fetch = base address).
REQ-024 SHALL, in DONE, hold ProgCtr until Start or Reset; IDLE without Start likewise holds.
REQ-025 SHALL, in RUN, apply first-match priority: Stall(hold all) > Halt(enter DONE, PC hold) > RetEn > CallEn > JumpAbsEn > BranchRelEn&&ALU_flag > increment.
REQ-026 SHALL compute relative target as ProgCtr + sign-extended Offset, modulo 2^PC_W.
REQ-027 SHALL wrap increment from 2^PC_W-1 to 0 without flag.
REQ-028 SHALL, on Call with stack not full, push ProgCtr+1 (mod 2^PC_W) and load JumpTarget.
REQ-029 SHALL, on Call with stack full, discard push, set RasOverflow, still load JumpTarget.
REQ-030 SHALL, on Ret with stack non-empty, load popped address; on empty, set RasUnderflow and increment.
REQ-031 SHALL ignore ProgSel outside 0..NUM_PROG-1 by loading PROG_BASE[0].
REQ-032 SHALL produce ProgCtr one cycle after the controlling inputs (single-cycle registered update, no combinational input-to-ProgCtr path).

Reset
REQ-033 SHALL, on Reset=1 at a rising edge, set ProgCtr=PROG_BASE[0], state IDLE, stack empty, RasOverflow=RasUnderflow=0.
REQ-034 SHALL give Reset priority over Start and all control inputs, including mid-call/mid-stall.

Structure
REQ-035 SHALL place state enum and default parameter values in shared package prog_seq_pkg.
REQ-036 SHALL implement the stack as sub-module ret_addr_stack (push, pop, clear, full, empty, top), RAS_DEPTH x PC_W.

Verification
REQ-037 SHALL test: Reset, Start=1 ProgSel=1 (PROG_BASE[1]=0x100), release -> ProgCtr 0x100, then 0x101, 0x102; Running=1.
REQ-038 SHALL test: PC=0x010, BranchRelEn=1 ALU_flag=1 Offset=0xFC -> 0x00C; ALU_flag=0 -> 0x011.
REQ-039 SHALL test: PC=0x7FF, no control -> 0x000; Offset=+3 at 0x7FE -> 0x001.
REQ-040 SHALL test: five nested Calls (RAS_DEPTH=4) from 0x020 -> RasOverflow=1 after fifth; four Rets return LIFO; fifth Ret -> RasUnderflow=1, PC increments.
REQ-041 SHALL test: Stall+CallEn together -> PC and stack unchanged; Halt -> Done=1, PC held; Reset mid-RUN -> ProgCtr=PROG_BASE[0], flags clear.
